// File: rtl/aiv_video_out_timing.sv
// Video output timing for the AIV overlay: framebuffer phase/strobe/frame-start, blanking and PAL-style syncs.
// Optional colour-bar source is enabled by defining AIV_TEST_PATTERN_EN.
module aiv_video_out_timing #(
`ifdef AIV_TEST_PATTERN_EN
  parameter int unsigned BAR_WIDTH     = 90,
`endif
  parameter int unsigned CLK_PER_PIXEL = 6,
  parameter int unsigned H_ACTIVE      = 720,
  parameter int unsigned H_FRONT       = 12,
  parameter int unsigned H_SYNC        = 64,
  parameter int unsigned H_BACK        = 68,
  parameter int unsigned V_ACTIVE      = 288,
  parameter int unsigned V_FRONT       = 2,
  parameter int unsigned V_SYNC        = 3,
  parameter int unsigned V_BACK        = 19
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic [2:0] clk_phase,
  output logic       pixel_ce_out,
  output logic       frame_start_flag_out,
  input  logic [2:0] rgb_111_in,
`ifdef AIV_TEST_PATTERN_EN
  input  logic       test_pattern,
`endif
  output logic [2:0] rgb_out,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       csync_n,
  output logic       video_active
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned PW      = $clog2(CLK_PER_PIXEL);
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);

  localparam logic [PW-1:0] PH_LAST = PW'(CLK_PER_PIXEL - 1);
  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [PW-1:0] phase, phase_nxt_c;
  logic [HW-1:0] h, h_nxt_c, h_q;
  logic [VW-1:0] v, v_nxt_c, v_q;
  logic          phase_last_c, h_last_c, v_last_c;
  logic          pce_c, frame_end_c;
  logic          act_c, hs_c, vs_c;
  logic [2:0]    pix_c;

  // Counter advance plus decode of the registered (output-aligned) position h_q/v_q.
  always_comb begin
    phase_last_c = (phase == PH_LAST);
    h_last_c     = (h == H_LAST);
    v_last_c     = (v == V_LAST);
    phase_nxt_c  = phase_last_c ? '0 : phase + PW'(1);
    h_nxt_c      = h;
    v_nxt_c      = v;
    if (phase_last_c) begin
      h_nxt_c = h_last_c ? '0 : h + HW'(1);
      if (h_last_c) v_nxt_c = v_last_c ? '0 : v + VW'(1);
    end
    pce_c       = (phase == '0) && (h < H_ACT) && (v < V_ACT);
    frame_end_c = phase_last_c && h_last_c && v_last_c;
    act_c       = (h_q < H_ACT) && (v_q < V_ACT);
    hs_c        = (h_q >= HS_BEG) && (h_q < HS_END);
    vs_c        = (v_q >= VS_BEG) && (v_q < VS_END);
    pix_c       = rgb_111_in;
`ifdef AIV_TEST_PATTERN_EN
    if (test_pattern) pix_c = 3'd7 - 3'((32'(h_q) / BAR_WIDTH) % 32'd8);
`endif
  end

  // Counters sit at the terminal state in reset so the first released cycle is the frame-start cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      phase                <= PH_LAST;
      h                    <= H_LAST;
      v                    <= V_LAST;
      h_q                  <= H_LAST;
      v_q                  <= V_LAST;
      clk_phase            <= 3'd0;
      pixel_ce_out         <= 1'b0;
      frame_start_flag_out <= 1'b0;
      rgb_out              <= 3'd0;
      hsync_n              <= 1'b1;
      vsync_n              <= 1'b1;
      csync_n              <= 1'b1;
      video_active         <= 1'b0;
    end else begin
      phase                <= phase_nxt_c;
      h                    <= h_nxt_c;
      v                    <= v_nxt_c;
      h_q                  <= h;
      v_q                  <= v;
      clk_phase            <= 3'(phase);
      pixel_ce_out         <= pce_c;
      frame_start_flag_out <= frame_end_c;
      // Framebuffer returns the pixel in the phase-1 cycle; capture it and the matching syncs together.
      if (clk_phase == 3'd1) begin
        rgb_out      <= act_c ? pix_c : 3'd0;
        video_active <= act_c;
        hsync_n      <= ~hs_c;
        vsync_n      <= ~vs_c;
        csync_n      <= ~(hs_c | vs_c);
      end
    end
  end

endmodule

// File: tb/tb_aiv_video_out_timing.sv
// Self-checking bench for aiv_video_out_timing using a small frame geometry (960 clk per frame).
module tb_aiv_video_out_timing;

  localparam int FRAME = 960;

  typedef struct packed {
    logic [2:0] ph;
    logic       pce;
    logic       fs;
    logic [2:0] rgb;
    logic       hs;
    logic       vs;
    logic       cs;
    logic       va;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] clk_phase;
  logic       pixel_ce_out;
  logic       frame_start_flag_out;
  logic [2:0] rgb_111_in;
  logic       test_pattern;
  logic [2:0] rgb_out;
  logic       hsync_n, vsync_n, csync_n, video_active;

  int         checks = 0;
  int         errors = 0;
  int         n;
  logic [2:0] hist[0:4095];
  logic       tp_hist[0:4095];
  bit         fixed_rgb;
  bit         rand_tp;
  logic [2:0] fixed_val;

  aiv_video_out_timing #(
`ifdef AIV_TEST_PATTERN_EN
    .BAR_WIDTH(2),
`endif
    .CLK_PER_PIXEL(6),
    .H_ACTIVE(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(5),
    .V_ACTIVE(4),  .V_FRONT(1), .V_SYNC(1), .V_BACK(2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .clk_phase(clk_phase),
    .pixel_ce_out(pixel_ce_out),
    .frame_start_flag_out(frame_start_flag_out),
    .rgb_111_in(rgb_111_in),
`ifdef AIV_TEST_PATTERN_EN
    .test_pattern(test_pattern),
`endif
    .rgb_out(rgb_out),
    .hsync_n(hsync_n),
    .vsync_n(vsync_n),
    .csync_n(csync_n),
    .video_active(video_active)
  );

  always #5 clk = ~clk;

  // Advance one clock, then drive fresh inputs for the new cycle and log them by cycle index.
  task automatic tick();
    @(posedge clk);
    #1;
    n++;
    rgb_111_in = fixed_rgb ? fixed_val : 3'($urandom);
`ifdef AIV_TEST_PATTERN_EN
    if (rand_tp) test_pattern = 1'($urandom);
`endif
    if (n >= 0 && n < 4096) begin
      hist[n]    = rgb_111_in;
      tp_hist[n] = test_pattern;
    end
  endtask

  task automatic do_reset(input int cycles);
    reset_n = 1'b0;
    repeat (cycles) tick();
  endtask

  task automatic release_reset();
    reset_n = 1'b1;
    n = -1;
    tick();
  endtask

  // Reference: cycle k after release; k=0 is the frame-start cycle, k=1 is phase 0 of pixel (0,0).
  function automatic exp_t exp_at(input int k);
    exp_t e;
    int m, pix, h, v, p, s;
    bit act;
    e.ph = 3'd0; e.pce = 1'b0; e.fs = 1'b0; e.rgb = 3'd0;
    e.hs = 1'b1; e.vs = 1'b1; e.cs = 1'b1; e.va = 1'b0;
    if (k == 0) begin
      e.ph = 3'd5;
      e.fs = 1'b1;
    end else if (k > 0) begin
      m     = (k - 1) % FRAME;
      pix   = m / 6;
      h     = pix % 20;
      v     = pix / 20;
      e.ph  = 3'(m % 6);
      e.pce = (m % 6 == 0) && (h < 10) && (v < 4);
      e.fs  = (m == FRAME - 1);
    end
    if (k >= 3) begin
      p    = (k - 3) / 6;
      h    = (p % 160) % 20;
      v    = (p % 160) / 20;
      s    = 2 + 6 * p;
      act  = (h < 10) && (v < 4);
      e.va = act;
      if (act) e.rgb = tp_hist[s] ? 3'(7 - (h / 2) % 8) : hist[s];
      e.hs = !(h >= 12 && h < 15);
      e.vs = !(v == 5);
      e.cs = e.hs & e.vs;
    end
    return e;
  endfunction

  task automatic test_reset();
    do_reset(int'($urandom_range(1, 4)));
    checks++;
    if ({clk_phase, pixel_ce_out, frame_start_flag_out, rgb_out, hsync_n, vsync_n, csync_n, video_active}
        !== 12'b000_0_0_000_1_1_1_0) begin
      errors++;
      $display("FAIL reset_values got %b exp %b",
               {clk_phase, pixel_ce_out, frame_start_flag_out, rgb_out, hsync_n, vsync_n, csync_n, video_active},
               12'b000_0_0_000_1_1_1_0);
    end
  endtask

  task automatic test_release();
    int gap;
    do_reset(2);
    release_reset();
    checks++;
    if (frame_start_flag_out !== 1'b1 || clk_phase !== 3'd5) begin
      errors++;
      $display("FAIL release_first fs=%b phase=%0d exp fs=1 phase=5", frame_start_flag_out, clk_phase);
    end
    tick();
    checks++;
    if (clk_phase !== 3'd0 || pixel_ce_out !== 1'b1) begin
      errors++;
      $display("FAIL release_second phase=%0d pce=%b exp phase=0 pce=1", clk_phase, pixel_ce_out);
    end
    gap = -1;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (frame_start_flag_out === 1'b1) begin
        gap = n;
        break;
      end
    end
    checks++;
    if (gap !== FRAME) begin
      errors++;
      $display("FAIL fs_period got %0d exp %0d", gap, FRAME);
    end
  endtask

  task automatic test_frames();
    exp_t e;
    int cnt;
    rand_tp = 1'b1;
    do_reset(1);
    release_reset();
    for (int f = 0; f < 3; f++) begin
      cnt = 0;
      for (int i = 0; i < FRAME; i++) begin
        tick();
        e = exp_at(n);
        if (pixel_ce_out === 1'b1) cnt++;
        checks++;
        if ({clk_phase, pixel_ce_out, frame_start_flag_out, rgb_out, hsync_n, vsync_n, csync_n, video_active} !== e) begin
          errors++;
          $display("FAIL frame_cmp n=%0d got %b exp %b", n,
                   {clk_phase, pixel_ce_out, frame_start_flag_out, rgb_out, hsync_n, vsync_n, csync_n, video_active}, e);
        end
      end
      checks++;
      if (cnt != 40) begin
        errors++;
        $display("FAIL pce_count frame=%0d got %0d exp 40", f, cnt);
      end
    end
    rand_tp = 1'b0;
    test_pattern = 1'b0;
  endtask

  task automatic test_rgb_const();
    int np, nr;
    exp_t e;
    fixed_rgb = 1'b1;
    fixed_val = 3'b101;
    do_reset(1);
    release_reset();
    np = -1;
    nr = -1;
    for (int i = 0; i < 100 && nr < 0; i++) begin
      if (np < 0 && pixel_ce_out === 1'b1) np = n;
      if (rgb_out !== 3'd0) nr = n;
      if (nr < 0) tick();
    end
    checks++;
    if (np < 0 || nr - np != 2) begin
      errors++;
      $display("FAIL rgb_latency first_pce=%0d first_rgb=%0d exp diff 2", np, nr);
    end
    for (int i = 0; i < FRAME; i++) begin
      tick();
      e = exp_at(n);
      checks++;
      if (rgb_out !== (e.va ? 3'b101 : 3'b000) || video_active !== e.va) begin
        errors++;
        $display("FAIL rgb_blank n=%0d got rgb=%b va=%b exp va=%b", n, rgb_out, video_active, e.va);
      end
    end
    fixed_rgb = 1'b0;
  endtask

  task automatic test_sync();
    int hc, vc;
    do_reset(1);
    release_reset();
    tick();
    tick();
    vc = 0;
    for (int l = 0; l < 8; l++) begin
      hc = 0;
      for (int i = 0; i < 120; i++) begin
        tick();
        if (hsync_n === 1'b0) hc++;
        if (vsync_n === 1'b0) vc++;
        checks++;
        if (csync_n !== (hsync_n & vsync_n)) begin
          errors++;
          $display("FAIL csync n=%0d got %b exp %b", n, csync_n, hsync_n & vsync_n);
        end
      end
      checks++;
      if (hc != 18) begin
        errors++;
        $display("FAIL hsync_width line=%0d got %0d exp 18", l, hc);
      end
    end
    checks++;
    if (vc != 120) begin
      errors++;
      $display("FAIL vsync_width got %0d exp 120", vc);
    end
  endtask

  task automatic test_mid_reset();
    int target;
    exp_t e;
    do_reset(1);
    release_reset();
    target = 283 + int'($urandom_range(0, 5));
    while (n < target) tick();
    reset_n = 1'b0;
    tick();
    checks++;
    if ({clk_phase, pixel_ce_out, frame_start_flag_out, rgb_out, hsync_n, vsync_n, csync_n, video_active}
        !== 12'b000_0_0_000_1_1_1_0) begin
      errors++;
      $display("FAIL midreset_values got %b exp %b",
               {clk_phase, pixel_ce_out, frame_start_flag_out, rgb_out, hsync_n, vsync_n, csync_n, video_active},
               12'b000_0_0_000_1_1_1_0);
    end
    release_reset();
    checks++;
    if (frame_start_flag_out !== 1'b1 || clk_phase !== 3'd5) begin
      errors++;
      $display("FAIL midreset_restart fs=%b phase=%0d exp fs=1 phase=5", frame_start_flag_out, clk_phase);
    end
    for (int i = 0; i < FRAME + 2; i++) begin
      tick();
      e = exp_at(n);
      checks++;
      if ({clk_phase, pixel_ce_out, frame_start_flag_out, rgb_out, hsync_n, vsync_n, csync_n, video_active} !== e) begin
        errors++;
        $display("FAIL midreset_cmp n=%0d got %b exp %b", n,
                 {clk_phase, pixel_ce_out, frame_start_flag_out, rgb_out, hsync_n, vsync_n, csync_n, video_active}, e);
      end
    end
  endtask

`ifdef AIV_TEST_PATTERN_EN
  task automatic test_pattern_bars();
    logic [2:0] bars[0:9];
    bars = '{3'd7, 3'd7, 3'd6, 3'd6, 3'd5, 3'd5, 3'd4, 3'd4, 3'd3, 3'd3};
    test_pattern = 1'b1;
    do_reset(1);
    release_reset();
    for (int h = 0; h < 10; h++) begin
      while (n < 3 + 6 * h + int'($urandom_range(0, 5))) tick();
      checks++;
      if (rgb_out !== bars[h]) begin
        errors++;
        $display("FAIL bar h=%0d got %0d exp %0d", h, rgb_out, bars[h]);
      end
    end
    test_pattern = 1'b0;
  endtask
`endif

  initial begin
    reset_n      = 1'b0;
    rgb_111_in   = 3'd0;
    test_pattern = 1'b0;
    fixed_rgb    = 1'b0;
    rand_tp      = 1'b0;
    fixed_val    = 3'd0;
    n            = 0;
    test_reset();
    test_release();
    test_frames();
    test_rgb_const();
    test_sync();
    test_mid_reset();
`ifdef AIV_TEST_PATTERN_EN
    test_pattern_bars();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
